// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
// States of the host-to-device transmit sequencer plus common byte codes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FAIL
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] ACK    = 8'hFA;
    localparam logic [7:0] RESEND = 8'hFE;
    localparam logic [7:0] BREAK  = 8'hF0;
    localparam logic [7:0] EXT    = 8'hE0;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Debounce for one PS/2 line: level moves only when all LEN samples agree.
// Also emits a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int unsigned LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic fall
);

    logic [LEN-1:0] sh_q, sh_d;
    logic           lvl_q, lvl_d;
    logic           fall_q, fall_d;

    // Shift in the raw pin and update the agreed level.
    always_comb begin
        sh_d   = {sh_q[LEN-2:0], raw};
        lvl_d  = lvl_q;
        if (&sh_q)
            lvl_d = 1'b1;
        else if (~|sh_q)
            lvl_d = 1'b0;
        fall_d = lvl_q & ~lvl_d;
    end

    // Idle PS/2 lines are pulled high, so reset to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '1;
            lvl_q  <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            lvl_q  <= lvl_d;
            fall_q <= fall_d;
        end
    end

    assign lvl  = lvl_q;
    assign fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter, open-drain via low-active enables.
// Define PS2_TX_RETRY_EN to retry a failed frame up to RETRY_MAX times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned RETRY_MAX      = 2
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       ps2_c,
    input  logic       ps2_d,
    output logic       ps2_c_oe,
    output logic       ps2_d_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CNT_MAX =
        (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [9:0]    sreg_q, sreg_d;
    logic          dbit_q, dbit_d;
    logic          done_q, done_d;
    logic          rdy_q;

    logic c_lvl, c_fall, d_lvl, unused_d_fall;
    logic accept, tmo, active, retry_ok;

    ps2_line_filter #(.LEN(FILTER_LEN)) u_filt_c (
        .clk  (clk_100mhz),
        .rst_n(rst_n),
        .raw  (ps2_c),
        .lvl  (c_lvl),
        .fall (c_fall)
    );

    ps2_line_filter #(.LEN(FILTER_LEN)) u_filt_d (
        .clk  (clk_100mhz),
        .rst_n(rst_n),
        .raw  (ps2_d),
        .lvl  (d_lvl),
        .fall (unused_d_fall)
    );

    assign accept = tx_valid & tx_ready;
    assign tmo    = (cnt_q == TMO_LAST);
    assign active = (state_q == ST_DATA) | (state_q == ST_ACK) |
                    (state_q == ST_WAIT_IDLE);

`ifdef PS2_TX_RETRY_EN
    logic [3:0] retry_q, retry_d;

    assign retry_ok = (retry_q < 4'(RETRY_MAX));

    // Count failed attempts of the current byte; cleared while idle.
    always_comb begin
        retry_d = retry_q;
        if (state_q == ST_IDLE)
            retry_d = '0;
        else if (state_q == ST_FAIL && retry_ok)
            retry_d = retry_q + 4'd1;
    end

    // Retry counter register.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n)
            retry_q <= '0;
        else
            retry_q <= retry_d;
    end
`else
    localparam int unsigned unused_retry_max = RETRY_MAX;

    assign retry_ok = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            sreg_q    <= '1;
            dbit_q    <= 1'b1;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            sreg_q    <= sreg_d;
            dbit_q    <= dbit_d;
            done_q    <= done_d;
            rdy_q     <= 1'b1;
        end
    end

    // Next-state sequencing of the host request and frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (accept) state_d = ST_INHIBIT;
            ST_INHIBIT:
                if (cnt_q == INH_LAST) state_d = ST_REQ;
            ST_REQ:
                state_d = ST_DATA;
            ST_DATA:
                if (c_fall) begin
                    if (bit_cnt_q == 4'd9) state_d = ST_ACK;
                end else if (tmo) begin
                    state_d = ST_FAIL;
                end
            ST_ACK:
                if (c_fall)
                    state_d = d_lvl ? ST_FAIL : ST_WAIT_IDLE;
                else if (tmo)
                    state_d = ST_FAIL;
            ST_WAIT_IDLE:
                if (c_lvl && d_lvl)
                    state_d = ST_IDLE;
                else if (tmo)
                    state_d = ST_FAIL;
            ST_FAIL:
                state_d = retry_ok ? ST_INHIBIT : ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Counters, byte latch and the serial bit pipeline.
    always_comb begin
        cnt_d     = '0;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        sreg_d    = sreg_q;
        dbit_d    = dbit_q;
        done_d    = (state_q == ST_WAIT_IDLE) && (state_d == ST_IDLE);

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == ST_INHIBIT)
            cnt_d = cnt_q + CW'(1);
        else if (active)
            cnt_d = c_fall ? '0 : cnt_q + CW'(1);

        if (state_d == ST_INHIBIT && state_q != ST_INHIBIT)
            bit_cnt_d = '0;
        else if (c_fall && (state_q == ST_DATA || state_q == ST_ACK)
                 && bit_cnt_q != 4'd11)
            bit_cnt_d = bit_cnt_q + 4'd1;

        if (accept) begin
            data_d = tx_data;
            par_d  = odd_parity(tx_data);
        end

        if (state_q == ST_INHIBIT && state_d == ST_REQ) begin
            sreg_d = {1'b1, par_q, data_q};
            dbit_d = 1'b0;
        end else if (state_q == ST_DATA && c_fall) begin
            dbit_d = sreg_q[0];
            sreg_d = {1'b1, sreg_q[9:1]};
        end
    end

    // Line enables and status outputs decoded from state.
    always_comb begin
        ps2_c_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
        ps2_d_oe = ((state_q == ST_REQ) || (state_q == ST_DATA)) && !dbit_q;
        busy     = (state_q != ST_IDLE);
        tx_ready = rdy_q && (state_q == ST_IDLE);
        tx_done  = done_q;
        tx_err   = (state_q == ST_FAIL) && !retry_ok;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Timing parameters are scaled down to keep the run short.
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TMO  = 3000;
    localparam int HALF = 50;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    typedef struct {
        logic [7:0] data;
        logic       nack;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic       ps2_c, ps2_d;
    logic       c_oe, d_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;

    int n_chk = 0;
    int n_err = 0;

    int   inh_cyc = 0, req_cyc = 0, inh_starts = 0;
    int   done_n = 0, err_n = 0, both_n = 0, done_busy_n = 0;
    logic c_prev = 1'b0, busy_prev = 1'b0;

    vec_t vecs [6];

    assign ps2_c = ~c_oe & dev_c;
    assign ps2_d = ~d_oe & dev_d;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (4),
        .RETRY_MAX     (2)
    ) dut (
        .clk_100mhz(clk),
        .rst_n     (rst_n),
        .ps2_c     (ps2_c),
        .ps2_d     (ps2_d),
        .ps2_c_oe  (c_oe),
        .ps2_d_oe  (d_oe),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    always @(negedge clk) begin
        if (c_oe && !d_oe) inh_cyc <= inh_cyc + 1;
        if (c_oe && d_oe) req_cyc <= req_cyc + 1;
        if (c_oe && !c_prev) inh_starts <= inh_starts + 1;
        if (tx_done) done_n <= done_n + 1;
        if (tx_err) err_n <= err_n + 1;
        if (tx_done && tx_err) both_n <= both_n + 1;
        if (tx_done && !(busy_prev && !busy))
            done_busy_n <= done_busy_n + 1;
        c_prev    <= c_oe;
        busy_prev <= busy;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_data(output bit ok);
        int n;
        n = 0;
        while (!(!c_oe && d_oe) && n < 20 * INH) begin
            @(negedge clk);
            n++;
        end
        ok = (!c_oe && d_oe);
    endtask

    task automatic dev_frame(input logic nack, input int nf,
                             output logic [10:0] s, output bit ok);
        s = '0;
        wait_data(ok);
        if (!ok) return;
        for (int i = 0; i < nf; i++) begin
            repeat (HALF) @(negedge clk);
            s[i] = ps2_d;
            if (i == 10 && !nack) begin
                dev_d = 1'b0;
                repeat (10) @(negedge clk);
            end
            dev_c = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_c = 1'b1;
        end
        dev_d = 1'b1;
    endtask

    task automatic wait_end(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = !busy;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v);
        logic [10:0] s;
        bit ok;
        int att, d0, e0, i0, r0, p0;
        att = v.nack ? ATTEMPTS : 1;
        d0 = done_n; e0 = err_n; i0 = inh_cyc;
        r0 = req_cyc; p0 = inh_starts;
        launch(v.data);
        for (int a = 0; a < att; a++) begin
            dev_frame(v.nack, 11, s, ok);
            chk("dev_sync", 32'(ok), 1);
            chk("frame", 32'(s), 32'({1'b1, v.exp_par, v.data, 1'b0}));
        end
        wait_end(ok);
        chk("end_idle", 32'(ok), 1);
        chk("done_pulses", done_n - d0, v.exp_done);
        chk("err_pulses", err_n - e0, v.exp_err);
        chk("inhibit_cycles", inh_cyc - i0, att * INH);
        chk("req_cycles", req_cyc - r0, att);
        chk("inhibit_phases", inh_starts - p0, att);
        chk("c_oe_released", 32'(c_oe), 0);
        chk("d_oe_released", 32'(d_oe), 0);
        chk("ready_after", 32'(tx_ready), 1);
        chk("busy_after", 32'(busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] s1, s2;
        bit ok;
        int n, k, d0, e0, p0;

        vecs[0] = '{8'hED, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{8'hF4, 1'b0, 1'b0, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 0, 1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1, 0};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1, 0};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 0, 1};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_c_oe", 32'(c_oe), 0);
        chk("rst_d_oe", 32'(d_oe), 0);
        chk("rst_ready", 32'(tx_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_err", 32'(tx_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(tx_ready), 1);

        for (int i = 0; i < 6; i++) run_row(vecs[i]);

        // Device never clocks: each attempt times out TMO cycles after DATA.
        d0 = done_n; e0 = err_n;
        launch(8'hA5);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_data(ok);
            chk("tmo_data_entry", 32'(ok), 1);
            k = 0;
            while (d_oe && k <= TMO + 100) begin
                @(negedge clk);
                k++;
            end
            chk("tmo_cycles", k, TMO);
            chk("tmo_c_oe", 32'(c_oe), 0);
            chk("tmo_err_now", 32'(tx_err), (a == ATTEMPTS - 1) ? 1 : 0);
        end
        wait_end(ok);
        chk("tmo_err_pulses", err_n - e0, 1);
        chk("tmo_done_pulses", done_n - d0, 0);
        chk("tmo_lines", 32'({c_oe, d_oe}), 0);

        // Reset while bit 4 of 0x00 is on the wire.
        d0 = done_n; e0 = err_n;
        launch(8'h00);
        dev_frame(1'b0, 5, s1, ok);
        chk("rst_mid_sync", 32'(ok), 1);
        chk("bit4_driven", 32'(d_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_c_oe", 32'(c_oe), 0);
        chk("rst_mid_d_oe", 32'(d_oe), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_done", done_n - d0, 0);
        chk("rst_mid_err", err_n - e0, 0);
        run_row('{8'hFF, 1'b0, 1'b1, 1, 0});

        // tx_valid held with a new byte during a transfer.
        d0 = done_n; p0 = inh_starts;
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hF4;
        dev_frame(1'b0, 11, s1, ok);
        chk("hold_sync1", 32'(ok), 1);
        n = 0;
        while (!tx_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("hold_done_seen", 32'(tx_done), 1);
        chk("hold_ready_at_done", 32'(tx_ready), 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("hold_reaccept", 32'(busy), 1);
        dev_frame(1'b0, 11, s2, ok);
        chk("hold_sync2", 32'(ok), 1);
        wait_end(ok);
        chk("hold_frame1", 32'(s1), 32'(11'b1_1_11101101_0));
        chk("hold_frame2", 32'(s2), 32'(11'b1_0_11110100_0));
        chk("hold_done_pulses", done_n - d0, 2);
        chk("hold_phases", inh_starts - p0, 2);

        chk("done_err_overlap", both_n, 0);
        chk("done_busy_edge", done_busy_n, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Sits beside the PS/2 receiver on the same ps2_c/ps2_d pins. Drives both lines open-drain through low-active output enables.
- Reports completion or error to the control logic via a valid/ready request and pulse outputs.

Parameters:
- INHIBIT_CYCLES, 12000: clock-inhibit time, 120 us at 100 MHz.
- TIMEOUT_CYCLES, 1500000: maximum wait for any device clock edge, 15 ms.
- FILTER_LEN, 4: debounce depth in samples.
- RETRY_MAX, 2: retries on failure. Used only with PS2_TX_RETRY_EN.

Ports:
- clk_100mhz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ps2_c  in  1  raw PS/2 clock pin level.
- ps2_d  in  1  raw PS/2 data pin level.
- ps2_c_oe  out  1  1 pulls the clock line low; 0 releases it.
- ps2_d_oe  out  1  1 pulls the data line low; 0 releases it.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE.
- busy  out  1  high whenever state is not IDLE; the receiver path ignores frames while high.
- tx_done  out  1  one-cycle pulse on acknowledged transfer.
- tx_err  out  1  one-cycle pulse on NACK or timeout.

Behaviour:
- Reset (asynchronous, immediate):
  - ps2_c_oe = ps2_d_oe = 0 (lines released).
  - tx_ready = 0 during reset, 1 from the first cycle after release.
  - busy, tx_done, tx_err = 0; state = IDLE.
  - Reset mid-transfer abandons the frame with no pulse.
- Line filtering: ps2_c and ps2_d each pass through a FILTER_LEN shift register.
  - The filtered level changes only when all samples agree.
  - fall_c = one-cycle pulse on a filtered clock 1->0 transition.
- Handshake: transfer starts when tx_valid && tx_ready on a clk edge.
  - tx_data is latched into a shift register.
  - Odd parity is latched as ~^tx_data.
  - tx_valid outside IDLE is ignored and not queued.
- State machine:
  - IDLE -> INHIBIT on accept.
  - INHIBIT: ps2_c_oe = 1 for exactly INHIBIT_CYCLES cycles, then -> REQ.
  - REQ: one cycle with ps2_c_oe = 1 and ps2_d_oe = 1 (start bit 0), then -> DATA. Clock is released at DATA entry.
  - DATA:
    - Falling edges 1..8: drive bit0..bit7, LSB first; ps2_d_oe = ~bit.
    - Falling edge 9: drive parity.
    - Falling edge 10: release data (stop bit 1), then -> ACK.
  - ACK: on falling edge 11, sample filtered data. 0 means ACK -> WAIT_IDLE; 1 means NACK -> FAIL.
  - WAIT_IDLE: wait until filtered clock and data are both 1, then pulse tx_done -> IDLE.
  - FAIL: release both lines, pulse tx_err -> IDLE.
- Timeout: a cycle counter is cleared on every fall_c and on each state entry, active in DATA, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES -> FAIL.
- Bit counter: 4 bits, 0..11, cleared on accept. No wrap; reaching 11 forces the ACK decision.
- Device clock edges seen while IDLE or INHIBIT are ignored.
- tx_done and tx_err are never asserted in the same cycle.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined:
  - FAIL re-enters INHIBIT with the same latched byte, up to RETRY_MAX times; busy stays high throughout.
  - tx_err pulses only after the final failure.
  - The retry counter clears on accept.
- Undefined: a single attempt, FAIL goes straight to IDLE; RETRY_MAX is unused.

Decomposition:
- Package ps2_pkg:
  - state enum.
  - Command constants: CMD_SET_LED 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF.
  - Device reply constants: ACK 8'hFA, RESEND 8'hFE, BREAK 8'hF0, EXT 8'hE0.
- Sub-module ps2_line_filter: debounce plus falling-edge pulse, instanced twice. The receiver path can reuse it.

Test Plan:
- tx_data = 8'hED with the device model clocking at 12.5 kHz and ACKing:
  - ps2_c_oe high for exactly 12000 cycles.
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; busy falls in the same cycle.
- tx_data = 8'hF4 -> parity 0 observed; ACK accepted; tx_ready returns 1.
- Device NACKs (data high on clock 11) for 8'h00 (parity 1):
  - Without macro: tx_err pulses once; both oe = 0.
  - With PS2_TX_RETRY_EN: 3 inhibit phases total, then tx_err.
- Device never clocks after REQ -> tx_err at 1500000 cycles after DATA entry; lines released.
- rst_n low during bit 4 -> both oe = 0 asynchronously; no tx_done/tx_err pulse; a fresh 8'hFF transfer then completes.
- tx_valid held high during a transfer with a different byte -> ignored. The byte accepted on the first IDLE cycle after done is sent correctly.
